smc_seq_ranker: RTL

//  Sequential, parametrised MOSFET current/transconductance ranker. It accepts N_CH transistor

---
 rtl/smc_seq_ranker_pkg.sv | 37 +++
 rtl/smc_seq_ranker_if.sv | 52 +++++
 rtl/smc_seq_ranker_dev.sv | 46 ++++
 rtl/smc_seq_ranker.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/smc_seq_ranker_pkg.sv
// Package smc_seq_pkg: shared types and width helpers for the MOSFET ranker.
//   state_t      - ranker FSM states (IDLE, LOAD, SUM, OUT)
//   calc_cw      - per-device value width: 3*DW-1
//   calc_sumw    - sum of the K rank weights 3..K+2: K*(K+5)/2
//   calc_ow      - output sum width: CW + clog2(SUMW+1)
//   calc_iw      - arrival-index width (at least 1 bit)
//   rank_weight  - weight of rank r: r+3 when mode0=1, else 1
package smc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SUM  = 2'd2,
    OUT  = 2'd3
  } state_t;

  function automatic int calc_cw(input int dw);
    return 3 * dw - 1;
  endfunction

  function automatic int calc_sumw(input int k);
    return (k * (k + 5)) / 2;
  endfunction

  function automatic int calc_ow(input int dw, input int k);
    return calc_cw(dw) + $clog2(calc_sumw(k) + 1);
  endfunction

  function automatic int calc_iw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int rank_weight(input int r, input logic mode0);
    return mode0 ? (r + 3) : 1;
  endfunction

endpackage

// File: rtl/smc_seq_ranker_if.sv
// Interface smc_seq_ranker_if: tuple input and ranked-sum output of the ranker.
//   in_valid, mode, W, V_GS, V_DS : front-end -> ranker
//   out_valid, out_n (, out_idx)  : ranker -> consumer
// Handshake: in_valid alone qualifies a tuple; there is no ready, so the
// ranker accepts every tuple presented while it is in IDLE or LOAD and
// silently drops tuples presented while it is summing/emitting. out_valid is
// a one-cycle pulse with no backpressure; out_n (and out_idx) are 0 when
// out_valid is low.
// Optional feature macro: SMC_SEQ_RANK_IDX_EN adds out_idx.
interface smc_seq_ranker_if #(
  parameter int DW   = 3,
  parameter int N_CH = 6,
  parameter int K    = 3
);
  import smc_seq_pkg::*;

  localparam int OW = calc_ow(DW, K);

  logic          in_valid;
  logic [1:0]    mode;
  logic [DW-1:0] W;
  logic [DW-1:0] V_GS;
  logic [DW-1:0] V_DS;
  logic          out_valid;
  logic [OW-1:0] out_n;

`ifdef SMC_SEQ_RANK_IDX_EN
  localparam int IW = calc_iw(N_CH);
  logic [IW-1:0] out_idx;

  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  out_valid, out_n, out_idx
  );

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output out_valid, out_n, out_idx
  );
`else
  modport master (
    output in_valid, mode, W, V_GS, V_DS,
    input  out_valid, out_n
  );

  modport slave (
    input  in_valid, mode, W, V_GS, V_DS,
    output out_valid, out_n
  );
`endif

endinterface

// File: rtl/smc_seq_ranker_dev.sv
// Module smc_seq_dev: combinational per-device evaluator.
//   w, v_gs, v_ds (DW) : transistor tuple
//   mode0              : 1 -> drain current I_D, 0 -> transconductance g_m
//   val (CW)           : floor(result / 3), 0 in cutoff (v_gs == 0)
// Intermediate products are formed at 3*DW bits so they never wrap; the
// quotient always fits in CW = 3*DW-1 bits.
module smc_seq_dev
  import smc_seq_pkg::*;
#(
  parameter int DW = 3,
  parameter int CW = calc_cw(DW)
) (
  input  logic [DW-1:0] w,
  input  logic [DW-1:0] v_gs,
  input  logic [DW-1:0] v_ds,
  input  logic          mode0,
  output logic [CW-1:0] val
);

  localparam int PW = 3 * DW;

  logic [PW-1:0] we;
  logic [PW-1:0] vg;
  logic [PW-1:0] vd;
  logic [PW-1:0] ov;
  logic [PW-1:0] prod;
  logic          in_tri;

  always_comb begin
    we     = PW'(w);
    vg     = PW'(v_gs);
    vd     = PW'(v_ds);
    // ov wraps when v_gs == 0, but that case is forced to 0 below.
    ov     = vg - PW'(1);
    in_tri = (ov > vd);
    prod   = '0;
    if (mode0) begin
      // in_tri guarantees 2*ov - vd is positive.
      prod = in_tri ? (we * vd * ((PW'(2) * ov) - vd)) : (we * ov * ov);
    end else begin
      prod = in_tri ? (PW'(2) * we * vd) : (PW'(2) * we * ov);
    end
    val = (vg == '0) ? '0 : CW'(prod / PW'(3));
  end

endmodule

// File: rtl/smc_seq_ranker.sv
// Module smc_seq_ranker: sequential MOSFET I_D / g_m ranker.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : smc_seq_ranker_if.slave (tuples in, weighted rank sum out)
//   state_dbg : current FSM state (smc_seq_pkg::state_t encoding)
// One transaction = N_CH tuples. Each tuple's value is insertion-sorted
// (descending, stable) into a register array as it arrives; after the last
// one, the weighted sum of K ranks taken from the top (mode[1]=1) or from the
// bottom (mode[1]=0) is registered and presented for one cycle.
// Optional feature macro: SMC_SEQ_RANK_IDX_EN carries each element's arrival
// index through the sort and reports the rank-0 selected element's index.
module smc_seq_ranker
  import smc_seq_pkg::*;
#(
  parameter int DW   = 3,
  parameter int N_CH = 6,
  parameter int K    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  smc_seq_ranker_if.slave    bus,
  output logic [1:0]         state_dbg
);

  localparam int CW   = calc_cw(DW);
  localparam int OW   = calc_ow(DW, K);
  localparam int CNTW = $clog2(N_CH + 1);
`ifdef SMC_SEQ_RANK_IDX_EN
  localparam int IW   = calc_iw(N_CH);
`endif

  state_t          state;
  state_t          state_nx;
  logic            ins_en;
  logic [CNTW-1:0] count;
  logic [CNTW-1:0] cur_cnt;
  logic [1:0]      mode_q;
  logic            dev_mode0;
  logic [CW-1:0]   dev_val;
  logic [CW-1:0]   val_arr [N_CH];
  logic [CW-1:0]   val_nx  [N_CH];
  logic [N_CH-1:0] ge;
  logic [OW-1:0]   sum_c;
  logic [OW-1:0]   sum_q;
`ifdef SMC_SEQ_RANK_IDX_EN
  logic [IW-1:0]   idx_arr [N_CH];
  logic [IW-1:0]   idx_nx  [N_CH];
  logic [IW-1:0]   idx_q;
`endif

  assign state_dbg = state;

  // The first tuple is evaluated with the mode presented alongside it; later
  // tuples use the latched mode.
  assign dev_mode0 = (state == IDLE) ? bus.mode[0] : mode_q[0];
  // In IDLE the array holds a finished transaction; insert as if empty.
  assign cur_cnt   = (state == IDLE) ? '0 : count;

  smc_seq_dev #(
    .DW (DW),
    .CW (CW)
  ) u_dev (
    .w     (bus.W),
    .v_gs  (bus.V_GS),
    .v_ds  (bus.V_DS),
    .mode0 (dev_mode0),
    .val   (dev_val)
  );

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ins_en   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.in_valid) begin
          ins_en   = 1'b1;
          state_nx = (N_CH == 1) ? SUM : LOAD;
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          ins_en = 1'b1;
          if (count == CNTW'(N_CH - 1)) begin
            state_nx = SUM;
          end
        end
      end
      SUM:     state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // ------------------------------------------------------ counter / mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      mode_q <= '0;
    end else begin
      if (ins_en) begin
        count <= cur_cnt + CNTW'(1);
      end else if (state == OUT) begin
        count <= '0;
      end
      if ((state == IDLE) && bus.in_valid) begin
        mode_q <= bus.mode;
      end
    end
  end

  // ------------------------------------------------------ insertion sort
  // ge[i]: occupied slot i outranks the new value. Because the array is
  // descending, ge is a prefix of ones; the new value lands at the first
  // zero and everything below it moves down one slot. Using >= keeps the
  // sort stable: equal earlier arrivals stay above the newcomer.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      ge[i] = (CNTW'(i) < cur_cnt) && (val_arr[i] >= dev_val);
    end
    val_nx[0] = ge[0] ? val_arr[0] : dev_val;
    for (int i = 1; i < N_CH; i++) begin
      if (ge[i]) begin
        val_nx[i] = val_arr[i];
      end else if (ge[i-1]) begin
        val_nx[i] = dev_val;
      end else begin
        val_nx[i] = val_arr[i-1];
      end
    end
  end

`ifdef SMC_SEQ_RANK_IDX_EN
  always_comb begin
    idx_nx[0] = ge[0] ? idx_arr[0] : IW'(cur_cnt);
    for (int i = 1; i < N_CH; i++) begin
      if (ge[i]) begin
        idx_nx[i] = idx_arr[i];
      end else if (ge[i-1]) begin
        idx_nx[i] = IW'(cur_cnt);
      end else begin
        idx_nx[i] = idx_arr[i-1];
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        val_arr[i] <= '0;
`ifdef SMC_SEQ_RANK_IDX_EN
        idx_arr[i] <= '0;
`endif
      end
    end else if (ins_en) begin
      for (int i = 0; i < N_CH; i++) begin
        val_arr[i] <= val_nx[i];
`ifdef SMC_SEQ_RANK_IDX_EN
        idx_arr[i] <= idx_nx[i];
`endif
      end
    end
  end

  // -------------------------------------------------------- weighted sum
  // Rank r is slot r from the top, or slot N_CH-1-r when counting from the
  // minimum.
  always_comb begin
    sum_c = '0;
    for (int r = 0; r < K; r++) begin
      sum_c = sum_c + (OW'(val_arr[mode_q[1] ? r : (N_CH - 1 - r)])
                       * OW'(rank_weight(r, mode_q[0])));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
`ifdef SMC_SEQ_RANK_IDX_EN
      idx_q <= '0;
`endif
    end else if (state == SUM) begin
      sum_q <= sum_c;
`ifdef SMC_SEQ_RANK_IDX_EN
      idx_q <= idx_arr[mode_q[1] ? 0 : (N_CH - 1)];
`endif
    end
  end

  // Outputs decode straight from the registered state, so they are clean
  // for the single OUT cycle and forced to 0 otherwise.
  assign bus.out_valid = (state == OUT);
  assign bus.out_n     = (state == OUT) ? sum_q : '0;
`ifdef SMC_SEQ_RANK_IDX_EN
  assign bus.out_idx   = (state == OUT) ? idx_q : '0;
`endif

endmodule
